// File: rtl/elev_pkg.sv
// Shared elevator definitions: FSM state encoding and the motion codes consumed by the LCD text stage.
package elev_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR = 2'd3;

  typedef enum logic [1:0] {
    MOVE_STOP = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } move_t;

  function automatic move_t stateToMove(input logic [1:0] state);
    case (state)
      ST_UP:   return MOVE_UP;
      ST_DOWN: return MOVE_DOWN;
      default: return MOVE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module elev_timer #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_en,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator controller: latches floor calls, moves one floor per TRAVEL_CYC, holds the door for DOOR_CYC.
// Optional ELEV_DOOR_REOPEN_EN: a call for the current floor while the door is open restarts the door time.
module elevator_ctrl
  import elev_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int TRAVEL_CYC = 50000000,
  parameter int DOOR_CYC   = 100000000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [N_FLOORS-1:0] iREQ,
  output logic [1:0]          oMOVE,
  output logic [2:0]          oFLOOR,
  output logic                oDOOR,
  output logic [N_FLOORS-1:0] oPEND,
  output logic                oUPD
);

  // Counters run from N-1 down to 0, so the period is exactly N cycles.
  localparam logic [31:0] TRAVEL_LOAD = 32'(TRAVEL_CYC - 1);
  localparam logic [31:0] DOOR_LOAD   = 32'(DOOR_CYC - 1);

  logic [1:0]          r_state, w_stateNext;
  logic [2:0]          r_floor, w_floorNext, w_hopFloor;
  logic [N_FLOORS-1:0] r_pend, w_clr, w_ignore, w_curMask, w_hopMask;
  logic                r_lastUp, w_lastUpNext;
  logic                w_here, w_above, w_below, w_hopHere, w_hopAhead;
  logic                w_travLoad, w_doorLoad, w_travDone, w_doorDone;
  logic                w_travEn, w_doorEn, w_reopen;
  logic [1:0]          r_movePrev;
  logic [2:0]          r_floorPrev;
  logic                r_first, r_upd;

  assign w_hopFloor = (r_state == ST_DOWN) ? r_floor - 3'd1 : r_floor + 3'd1;

  always_comb begin
    w_curMask  = '0;
    w_hopMask  = '0;
    w_here     = 1'b0;
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_hopHere  = 1'b0;
    w_hopAhead = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i == int'(r_floor)) begin
        w_curMask[i] = 1'b1;
        w_here       = r_pend[i];
      end
      if (i > int'(r_floor)) w_above = w_above | r_pend[i];
      if (i < int'(r_floor)) w_below = w_below | r_pend[i];
      if (i == int'(w_hopFloor)) begin
        w_hopMask[i] = 1'b1;
        w_hopHere    = r_pend[i];
      end
      if ((r_state == ST_DOWN) ? (i < int'(w_hopFloor)) : (i > int'(w_hopFloor)))
        w_hopAhead = w_hopAhead | r_pend[i];
    end
  end

  assign w_ignore = (r_state == ST_DOOR) ? w_curMask : '0;
`ifdef ELEV_DOOR_REOPEN_EN
  assign w_reopen = (r_state == ST_DOOR) && ((iREQ & w_curMask) != '0);
`else
  assign w_reopen = 1'b0;
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_floorNext  = r_floor;
    w_lastUpNext = r_lastUp;
    w_clr        = '0;
    w_travLoad   = 1'b0;
    w_doorLoad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_here) begin
          w_stateNext = ST_DOOR;
          w_clr       = w_curMask;
          w_doorLoad  = 1'b1;
        end else if (w_above) begin
          w_stateNext  = ST_UP;
          w_lastUpNext = 1'b1;
          w_travLoad   = 1'b1;
        end else if (w_below) begin
          w_stateNext  = ST_DOWN;
          w_lastUpNext = 1'b0;
          w_travLoad   = 1'b1;
        end
      end
      ST_UP, ST_DOWN: begin
        if (w_travDone) begin
          w_floorNext = w_hopFloor;
          w_travLoad  = 1'b1;
          if (w_hopHere) begin
            w_stateNext = ST_DOOR;
            w_clr       = w_hopMask;
            w_doorLoad  = 1'b1;
          end else if (!w_hopAhead) begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: begin
        if (w_reopen) begin
          w_doorLoad = 1'b1;
        end else if (w_doorDone) begin
          // Prefer the direction we were already travelling before reversing.
          if (r_lastUp ? w_above : w_below) begin
            w_stateNext = r_lastUp ? ST_UP : ST_DOWN;
            w_travLoad  = 1'b1;
          end else if (r_lastUp ? w_below : w_above) begin
            w_stateNext  = r_lastUp ? ST_DOWN : ST_UP;
            w_lastUpNext = !r_lastUp;
            w_travLoad   = 1'b1;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= ST_IDLE;
      r_floor  <= '0;
      r_pend   <= '0;
      r_lastUp <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_floor  <= w_floorNext;
      r_lastUp <= w_lastUpNext;
      r_pend   <= (r_pend | (iREQ & ~w_ignore)) & ~w_clr;
    end
  end

  // Display refresh strobe: compare against last cycle's outputs; r_first covers reset release.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_movePrev  <= '0;
      r_floorPrev <= '0;
      r_first     <= 1'b1;
      r_upd       <= 1'b0;
    end else begin
      r_movePrev  <= oMOVE;
      r_floorPrev <= r_floor;
      r_first     <= 1'b0;
      r_upd       <= r_first || (oMOVE != r_movePrev) || (r_floor != r_floorPrev);
    end
  end

  assign w_travEn = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_doorEn = (r_state == ST_DOOR);

  elev_timer #(.WIDTH(32)) u_travelTimer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .i_load   (w_travLoad),
    .i_loadVal(TRAVEL_LOAD),
    .i_en     (w_travEn),
    .o_done   (w_travDone)
  );

  elev_timer #(.WIDTH(32)) u_doorTimer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .i_load   (w_doorLoad),
    .i_loadVal(DOOR_LOAD),
    .i_en     (w_doorEn),
    .o_done   (w_doorDone)
  );

  assign oMOVE  = stateToMove(r_state);
  assign oFLOOR = r_floor;
  assign oDOOR  = (r_state == ST_DOOR);
  assign oPEND  = r_pend;
  assign oUPD   = r_upd;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl (4 floors, 4-cycle travel, 3-cycle door): vector table, corner sequences, random calls vs. a reference model.
module tb_elevator_ctrl;

  localparam int NF     = 4;
  localparam int TRAV_C = 4;
  localparam int DOOR_C = 3;

  logic          iCLK;
  logic          iRST_N;
  logic [NF-1:0] iREQ;
  logic [1:0]    oMOVE;
  logic [2:0]    oFLOOR;
  logic          oDOOR;
  logic [NF-1:0] oPEND;
  logic          oUPD;

  int total = 0;
  int bad   = 0;

  elevator_ctrl #(.N_FLOORS(NF), .TRAVEL_CYC(TRAV_C), .DOOR_CYC(DOOR_C)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iREQ  (iREQ),
    .oMOVE (oMOVE),
    .oFLOOR(oFLOOR),
    .oDOOR (oDOOR),
    .oPEND (oPEND),
    .oUPD  (oUPD)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Reference model: floor number, direction (+1/-1/0), remaining door cycles, cycles spent on the current hop.
  int       mFloor, mDir, mDoor, mTrav, mLast;
  bit [3:0] mPend;
  bit       mChg, eUpd;

  typedef struct {
    logic [3:0] req;
    logic [1:0] move;
    logic [2:0] floor;
    logic       door;
    logic [3:0] pend;
    logic       upd;
  } vec_t;

  vec_t vecs[18];

  task automatic modelReset();
    mFloor = 0; mDir = 0; mDoor = 0; mTrav = 0; mLast = 1;
    mPend = '0; mChg = 1'b1; eUpd = 1'b0;
  endtask

  function automatic bit pendBeyond(input bit [3:0] p, input int f, input int d);
    for (int i = 0; i < NF; i++)
      if (p[i] && ((d > 0 && i > f) || (d < 0 && i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input logic [3:0] req);
    bit [3:0] oldP, setP, clrP;
    int oldF, oldD;
    bit reopen;
    oldP = mPend; setP = req; clrP = '0; oldF = mFloor; oldD = mDir; reopen = 1'b0;
    if (mDoor > 0) begin
      setP[mFloor] = 1'b0;
`ifdef ELEV_DOOR_REOPEN_EN
      reopen = req[mFloor];
`endif
    end
    if (mDoor > 0) begin
      if (reopen) mDoor = DOOR_C;
      else begin
        mDoor--;
        if (mDoor == 0) begin
          if (pendBeyond(oldP, mFloor, mLast)) begin mDir = mLast; mTrav = 0; end
          else if (pendBeyond(oldP, mFloor, -mLast)) begin mLast = -mLast; mDir = mLast; mTrav = 0; end
        end
      end
    end else if (mDir != 0) begin
      mTrav++;
      if (mTrav == TRAV_C) begin
        mTrav = 0;
        mFloor += mDir;
        if (oldP[mFloor]) begin clrP[mFloor] = 1'b1; mDir = 0; mDoor = DOOR_C; end
        else if (!pendBeyond(oldP, mFloor, mDir)) mDir = 0;
      end
    end else begin
      if (oldP[mFloor]) begin clrP[mFloor] = 1'b1; mDoor = DOOR_C; end
      else if (pendBeyond(oldP, mFloor, 1)) begin mDir = 1; mLast = 1; mTrav = 0; end
      else if (pendBeyond(oldP, mFloor, -1)) begin mDir = -1; mLast = -1; mTrav = 0; end
    end
    mPend = (oldP | setP) & ~clrP;
    eUpd  = mChg;
    mChg  = (mFloor != oldF) || (mDir != oldD);
  endtask

  function automatic logic [1:0] expMove();
    return (mDir > 0) ? 2'd1 : (mDir < 0) ? 2'd2 : 2'd0;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    iREQ = req;
    @(posedge iCLK);
    if (iRST_N) modelStep(req);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".move"},  8'(oMOVE),  8'(expMove()));
    cmp({tag, ".floor"}, 8'(oFLOOR), 8'(mFloor));
    cmp({tag, ".door"},  8'(oDOOR),  8'(mDoor > 0));
    cmp({tag, ".pend"},  8'(oPEND),  8'(mPend));
    cmp({tag, ".upd"},   8'(oUPD),   8'(eUpd));
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, ".move"},  8'(oMOVE),  8'd0);
    cmp({tag, ".floor"}, 8'(oFLOOR), 8'd0);
    cmp({tag, ".door"},  8'(oDOOR),  8'd0);
    cmp({tag, ".pend"},  8'(oPEND),  8'd0);
    cmp({tag, ".upd"},   8'(oUPD),   8'd0);
  endtask

  initial begin
    // Call at floor 0 (door only), then call to floor 2 (two hops then door).
    vecs[0]  = '{4'b0001, 2'd0, 3'd0, 1'b0, 4'b0001, 1'b0};
    vecs[1]  = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0000, 2'd0, 3'd0, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{4'b0100, 2'd0, 3'd0, 1'b0, 4'b0100, 1'b0};
    vecs[6]  = '{4'b0000, 2'd1, 3'd0, 1'b0, 4'b0100, 1'b0};
    vecs[7]  = '{4'b0000, 2'd1, 3'd0, 1'b0, 4'b0100, 1'b1};
    vecs[8]  = '{4'b0000, 2'd1, 3'd0, 1'b0, 4'b0100, 1'b0};
    vecs[9]  = '{4'b0000, 2'd1, 3'd0, 1'b0, 4'b0100, 1'b0};
    vecs[10] = '{4'b0000, 2'd1, 3'd1, 1'b0, 4'b0100, 1'b0};
    vecs[11] = '{4'b0000, 2'd1, 3'd1, 1'b0, 4'b0100, 1'b1};
    vecs[12] = '{4'b0000, 2'd1, 3'd1, 1'b0, 4'b0100, 1'b0};
    vecs[13] = '{4'b0000, 2'd1, 3'd1, 1'b0, 4'b0100, 1'b0};
    vecs[14] = '{4'b0000, 2'd0, 3'd2, 1'b1, 4'b0000, 1'b0};
    vecs[15] = '{4'b0000, 2'd0, 3'd2, 1'b1, 4'b0000, 1'b1};
    vecs[16] = '{4'b0000, 2'd0, 3'd2, 1'b1, 4'b0000, 1'b0};
    vecs[17] = '{4'b0000, 2'd0, 3'd2, 1'b0, 4'b0000, 1'b0};

    iRST_N = 1'b0;
    iREQ   = '0;
    modelReset();
    repeat (2) @(posedge iCLK);
    #1;
    checkReset("rst");
    @(negedge iCLK);
    iRST_N = 1'b1;
    applyStimulus(4'b0000);
    cmp("rst.updPulse", 8'(oUPD), 8'd1);
    applyStimulus(4'b0000);
    cmp("rst.updEnd", 8'(oUPD), 8'd0);

    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].req);
      cmp($sformatf("vec%0d.move", v),  8'(oMOVE),  8'(vecs[v].move));
      cmp($sformatf("vec%0d.floor", v), 8'(oFLOOR), 8'(vecs[v].floor));
      cmp($sformatf("vec%0d.door", v),  8'(oDOOR),  8'(vecs[v].door));
      cmp($sformatf("vec%0d.pend", v),  8'(oPEND),  8'(vecs[v].pend));
      cmp($sformatf("vec%0d.upd", v),   8'(oUPD),   8'(vecs[v].upd));
    end

    // Calls above and below at once from floor 2: up to 3 first, then reverse to 0.
    applyStimulus(4'b1001);
    checkOutput("both.c1");
    for (int c = 2; c <= 25; c++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("both.c%0d", c));
      if (c == 6) begin
        cmp("both.topFloor", 8'(oFLOOR), 8'd3);
        cmp("both.topDoor",  8'(oDOOR),  8'd1);
        cmp("both.topPend",  8'(oPEND),  8'b0001);
      end
      if (c == 24) begin
        cmp("both.endFloor", 8'(oFLOOR), 8'd0);
        cmp("both.endDoor",  8'(oDOOR),  8'd0);
        cmp("both.endMove",  8'(oMOVE),  8'd0);
        cmp("both.endPend",  8'(oPEND),  8'd0);
      end
    end

    // Call for the current floor while the door is open at floor 1.
    applyStimulus(4'b0010);
    checkOutput("reo.c1");
    for (int c = 2; c <= 6; c++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("reo.c%0d", c));
    end
    cmp("reo.doorOpen", 8'(oDOOR), 8'd1);
    cmp("reo.floor", 8'(oFLOOR), 8'd1);
    applyStimulus(4'b0000);
    checkOutput("reo.c7");
    applyStimulus(4'b0010);
    checkOutput("reo.c8");
    cmp("reo.pendNotLatched", 8'(oPEND), 8'd0);
    cmp("reo.doorAtReq", 8'(oDOOR), 8'd1);
    applyStimulus(4'b0000);
    checkOutput("reo.c9");
`ifdef ELEV_DOOR_REOPEN_EN
    cmp("reo.doorHeld", 8'(oDOOR), 8'd1);
    applyStimulus(4'b0000);
    checkOutput("reo.c10");
    cmp("reo.doorHeld2", 8'(oDOOR), 8'd1);
    applyStimulus(4'b0000);
    checkOutput("reo.c11");
    cmp("reo.doorClosed", 8'(oDOOR), 8'd0);
`else
    cmp("reo.doorClosed", 8'(oDOOR), 8'd0);
`endif
    repeat (3) begin
      applyStimulus(4'b0000);
      checkOutput("reo.settle");
    end

    // Asynchronous reset while travelling from floor 1 toward 3.
    applyStimulus(4'b1000);
    checkOutput("mid.c1");
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(4'b0000);
      checkOutput($sformatf("mid.c%0d", c));
    end
    cmp("mid.moving", 8'(oMOVE), 8'd1);
    cmp("mid.pendSet", 8'(oPEND), 8'b1000);
    iRST_N = 1'b0;
    #1;
    checkReset("mid.rst");
    modelReset();
    @(negedge iCLK);
    iRST_N = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("mid.release");
    cmp("mid.updPulse", 8'(oUPD), 8'd1);

    for (int c = 0; c < 800; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(r);
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
